score_eval: RTL

//  Downstream of the DTW pose-matching pipeline. Consumes one 32-bit DTW score per

---
 rtl/score_eval_pkg.sv | 21 ++
 rtl/score_eval.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/score_eval_pkg.sv
// score_eval_pkg: shared types for the DTW score evaluator.
//   grade_t : 3-level quality grade reported with each completed set
//   state_t : evaluator FSM states
//   GRADE_W : width of the grade output
package score_eval_pkg;

  localparam int GRADE_W = 2;

  typedef enum logic [GRADE_W-1:0] {
    POOR = 2'd0,
    OK   = 2'd1,
    GOOD = 2'd2
  } grade_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EVAL    = 2'd1,
    REPORT  = 2'd2
  } state_t;

endpackage

// File: rtl/score_eval.sv
// score_eval: accumulates 2**REPS_LOG2 DTW scores (one per done rising edge) into a
// set and reports average, min, max and a grade on a valid/ack handshake.
// Lower score is better.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   score, done           DTW score, sampled on a rising edge of done
//   clear                 synchronous abort of the current set (highest priority)
//   thr_good, thr_ok      grade thresholds, sampled in the EVAL cycle
//   result_valid/ack      result handshake; result fields held while valid
//   avg, min_score,
//   max_score, grade      registered results of the last evaluated set
//   rep_cnt               scores accepted into the current set
//   drop_err              sticky: a score was discarded while a result was pending
//
// Optional feature (macro SCORE_EVAL_HIST_EN): adds hist_idx/hist_data, a read port
// onto a shadow copy of the per-set score history taken at evaluation time.
module score_eval
  import score_eval_pkg::*;
#(
  parameter int SCORE_WIDTH = 32,
  parameter int REPS_LOG2   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SCORE_WIDTH-1:0] score,
  input  logic                   done,
  input  logic                   clear,
  input  logic [SCORE_WIDTH-1:0] thr_good,
  input  logic [SCORE_WIDTH-1:0] thr_ok,
  output logic                   result_valid,
  input  logic                   result_ack,
  output logic [SCORE_WIDTH-1:0] avg,
  output logic [SCORE_WIDTH-1:0] min_score,
  output logic [SCORE_WIDTH-1:0] max_score,
  output logic [GRADE_W-1:0]     grade,
  output logic [REPS_LOG2:0]     rep_cnt,
  output logic                   drop_err
`ifdef SCORE_EVAL_HIST_EN
  ,
  input  logic [((REPS_LOG2 > 0) ? REPS_LOG2 : 1)-1:0] hist_idx,
  output logic [SCORE_WIDTH-1:0]                       hist_data
`endif
);

  localparam int SUM_WIDTH = SCORE_WIDTH + REPS_LOG2;
  localparam int REPS      = 1 << REPS_LOG2;
  localparam int CNT_W     = REPS_LOG2 + 1;
  localparam int IDX_W     = (REPS_LOG2 > 0) ? REPS_LOG2 : 1;

  localparam logic [SCORE_WIDTH-1:0] MIN_INIT = '1;

  state_t                 state_q, state_d;
  logic                   done_q;
  logic                   evt;

  logic [SUM_WIDTH-1:0]   sum_q;
  logic [SCORE_WIDTH-1:0] min_q, max_q;
  logic [CNT_W-1:0]       cnt_q;

  // accept : score enters the set this cycle
  // restart: set accumulators return to empty (ack); accept may stack on top
  // drop   : score arrived while a result was pending and is discarded
  logic                   accept, restart, drop;

  logic [SUM_WIDTH-1:0]   sum_base;
  logic [SCORE_WIDTH-1:0] min_base, max_base;
  logic [CNT_W-1:0]       cnt_base;

  logic [SCORE_WIDTH-1:0] avg_q, minr_q, maxr_q;
  grade_t                 grade_q;
  logic                   drop_q;

  logic [SCORE_WIDTH-1:0] avg_calc;
  grade_t                 grade_calc;

  assign evt = done & ~done_q;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    restart = 1'b0;
    drop    = 1'b0;
    case (state_q)
      COLLECT: begin
        if (evt) begin
          accept = 1'b1;
          if (cnt_q == CNT_W'(REPS - 1)) state_d = EVAL;
        end
      end
      EVAL: begin
        state_d = REPORT;
        // Accumulators still hold the set being evaluated, so a score here is lost.
        if (evt) drop = 1'b1;
      end
      REPORT: begin
        if (result_ack) begin
          restart = 1'b1;
          state_d = COLLECT;
          // Same-cycle event becomes rep 1 of the next set; with one rep per set
          // that single score already completes it.
          if (evt) begin
            accept = 1'b1;
            if (REPS == 1) state_d = EVAL;
          end
        end else if (evt) begin
          drop = 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase
    if (clear) begin
      state_d = COLLECT;
      accept  = 1'b0;
      restart = 1'b0;
      drop    = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Set accumulation
  // ---------------------------------------------------------------------------
  always_comb begin
    sum_base = restart ? '0       : sum_q;
    min_base = restart ? MIN_INIT : min_q;
    max_base = restart ? '0       : max_q;
    cnt_base = restart ? '0       : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      min_q  <= MIN_INIT;
      max_q  <= '0;
      cnt_q  <= '0;
      drop_q <= 1'b0;
    end else if (clear) begin
      sum_q  <= '0;
      min_q  <= MIN_INIT;
      max_q  <= '0;
      cnt_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      if (accept) begin
        sum_q <= sum_base + SUM_WIDTH'(score);
        min_q <= (score < min_base) ? score : min_base;
        max_q <= (score > max_base) ? score : max_base;
        cnt_q <= cnt_base + CNT_W'(1);
      end else if (restart) begin
        sum_q <= '0;
        min_q <= MIN_INIT;
        max_q <= '0;
        cnt_q <= '0;
      end
      if (drop) drop_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Evaluation: results registered in the EVAL cycle and held until the next one
  // ---------------------------------------------------------------------------
  assign avg_calc = SCORE_WIDTH'(sum_q >> REPS_LOG2);

  always_comb begin
    if (avg_calc <= thr_good)    grade_calc = GOOD;
    else if (avg_calc <= thr_ok) grade_calc = OK;
    else                         grade_calc = POOR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_q   <= '0;
      minr_q  <= '0;
      maxr_q  <= '0;
      grade_q <= POOR;
    end else if (state_q == EVAL && !clear) begin
      avg_q   <= avg_calc;
      minr_q  <= min_q;
      maxr_q  <= max_q;
      grade_q <= grade_calc;
    end
  end

  assign result_valid = (state_q == REPORT);
  assign avg          = avg_q;
  assign min_score    = minr_q;
  assign max_score    = maxr_q;
  assign grade        = grade_q;
  assign rep_cnt      = cnt_q;
  assign drop_err     = drop_q;

`ifdef SCORE_EVAL_HIST_EN
  // ---------------------------------------------------------------------------
  // Score history: written in arrival order, snapshotted at EVAL so the host can
  // read the finished set while the next one is being collected.
  // ---------------------------------------------------------------------------
  logic [SCORE_WIDTH-1:0] hist_rf [REPS];
  logic [SCORE_WIDTH-1:0] hist_sh [REPS];

  always_ff @(posedge clk) begin
    if (accept) hist_rf[cnt_base[IDX_W-1:0]] <= score;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REPS; i++) hist_sh[i] <= '0;
    end else if (state_q == EVAL && !clear) begin
      for (int i = 0; i < REPS; i++) hist_sh[i] <= hist_rf[i];
    end
  end

  assign hist_data = hist_sh[hist_idx];
`endif

endmodule
